// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling with start-bit
// validation, one-byte holding register on a valid/ready interface.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] d_rx,
    output logic       vld_rx,
    input  logic       rdy_rx,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    localparam logic [15:0] LAST_HALF = 16'(HALF_BIT - 1);
    localparam logic [15:0] LAST_BIT  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        sync1, rxs;
    logic        done, done_n;
    logic [7:0]  d_rx_n;
    logic        vld_rx_n, ferr_n, ovr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            done    <= 1'b0;
            d_rx    <= '0;
            vld_rx  <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            done    <= done_n;
            d_rx    <= d_rx_n;
            vld_rx  <= vld_rx_n;
            ferr    <= ferr_n;
            ovr     <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == LAST_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == LAST_BIT) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == LAST_BIT) begin
                    cnt_n = '0;
                    if (rxs) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A consume and a new load in the same cycle keep vld_rx high.
    always_comb begin
        d_rx_n   = d_rx;
        vld_rx_n = vld_rx;
        ovr_n    = 1'b0;
        if (vld_rx && rdy_rx) begin
            vld_rx_n = 1'b0;
        end
        if (done) begin
            if (!vld_rx || rdy_rx) begin
                d_rx_n   = shreg;
                vld_rx_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] d_rx;
    logic       vld_rx;
    logic       rdy_rx;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int n_run;
    int n_fail;
    int ferr_cnt;
    int ovr_cnt;
    logic [7:0] xfers[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT(CPB / 2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .d_rx(d_rx),
        .vld_rx(vld_rx),
        .rdy_rx(rdy_rx),
        .ferr(ferr),
        .ovr(ovr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovr) ovr_cnt++;
        if (vld_rx && rdy_rx) xfers.push_back(d_rx);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_bit;
        tick(CPB);
    endtask

    task automatic wait_vld(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (vld_rx) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        rdy_rx = 1'b0;
        tick(3);
        n_run++;
        if ({d_rx, vld_rx, ferr, ovr, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got d=%h v=%b f=%b o=%b b=%b want all 0",
                     d_rx, vld_rx, ferr, ovr, busy);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single;
        bit ok;
        int fb = ferr_cnt;
        int ob = ovr_cnt;
        bit stable = 1'b1;
        rdy_rx = 1'b0;
        send_frame(8'hA5, 1'b1);
        wait_vld(20, ok);
        n_run++;
        if (!ok || d_rx !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_data: got v=%b d=%h want v=1 d=a5", vld_rx, d_rx);
        end
        for (int i = 0; i < 110; i++) begin
            if (!vld_rx || d_rx !== 8'hA5) stable = 1'b0;
            tick(1);
        end
        n_run++;
        if (!stable) begin
            n_fail++;
            $display("FAIL single_hold: got v=%b d=%h want v=1 d=a5", vld_rx, d_rx);
        end
        rdy_rx = 1'b1;
        tick(1);
        rdy_rx = 1'b0;
        n_run++;
        if (vld_rx !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consume: got vld=%b want 0", vld_rx);
        end
        n_run++;
        if (ferr_cnt != fb || ovr_cnt != ob) begin
            n_fail++;
            $display("FAIL single_flags: got ferr=%0d ovr=%0d want 0 0",
                     ferr_cnt - fb, ovr_cnt - ob);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [3];
        int xb = xfers.size();
        int ob = ovr_cnt;
        exp[0] = 8'h00;
        exp[1] = 8'hFF;
        exp[2] = 8'h55;
        rdy_rx = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
        tick(20);
        rdy_rx = 1'b0;
        n_run++;
        if (xfers.size() - xb != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 3", xfers.size() - xb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_run++;
                if (xfers[xb + i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h want %h", i, xfers[xb + i], exp[i]);
                end
            end
        end
        n_run++;
        if (ovr_cnt != ob) begin
            n_fail++;
            $display("FAIL b2b_ovr: got %0d want 0", ovr_cnt - ob);
        end
    endtask

    task automatic test_glitch;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_hi: got %b want 1", busy);
        end
        tick(8);
        n_run++;
        if (busy !== 1'b0 || vld_rx !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: got busy=%b vld=%b want 0 0", busy, vld_rx);
        end
        tick(CPB * 12);
        n_run++;
        if (vld_rx !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_novld: got vld=%b want 0", vld_rx);
        end
    endtask

    task automatic test_framing;
        bit ok;
        int fb = ferr_cnt;
        int xb = xfers.size();
        send_frame(8'h3C, 1'b0);
        tick(40);
        rxd = 1'b1;
        tick(20);
        n_run++;
        if (ferr_cnt - fb != 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d want 1", ferr_cnt - fb);
        end
        n_run++;
        if (vld_rx !== 1'b0 || xfers.size() != xb) begin
            n_fail++;
            $display("FAIL ferr_novld: got vld=%b want 0", vld_rx);
        end
        send_frame(8'h81, 1'b1);
        wait_vld(20, ok);
        n_run++;
        if (!ok || d_rx !== 8'h81) begin
            n_fail++;
            $display("FAIL ferr_recover: got v=%b d=%h want v=1 d=81", vld_rx, d_rx);
        end
        rdy_rx = 1'b1;
        tick(1);
        rdy_rx = 1'b0;
        tick(4);
    endtask

    task automatic test_overrun;
        int ob = ovr_cnt;
        int xb;
        rdy_rx = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        n_run++;
        if (ovr_cnt - ob != 1) begin
            n_fail++;
            $display("FAIL ovr_count: got %0d want 1", ovr_cnt - ob);
        end
        n_run++;
        if (vld_rx !== 1'b1 || d_rx !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_keep: got v=%b d=%h want v=1 d=11", vld_rx, d_rx);
        end
        rdy_rx = 1'b1;
        tick(1);
        rdy_rx = 1'b0;
        tick(4);
        ob = ovr_cnt;
        send_frame(8'h11, 1'b1);
        xb = xfers.size();
        // Stop sample lands on edge 155 of the frame; handoff on edge 156.
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(155);
                rdy_rx = 1'b1;
                tick(1);
                rdy_rx = 1'b0;
            end
        join
        tick(4);
        n_run++;
        if (vld_rx !== 1'b1 || d_rx !== 8'h22) begin
            n_fail++;
            $display("FAIL handoff_data: got v=%b d=%h want v=1 d=22", vld_rx, d_rx);
        end
        n_run++;
        if (ovr_cnt != ob) begin
            n_fail++;
            $display("FAIL handoff_ovr: got %0d want 0", ovr_cnt - ob);
        end
        n_run++;
        if (xfers.size() - xb != 1 || xfers[xfers.size() - 1] !== 8'h11) begin
            n_fail++;
            $display("FAIL handoff_xfer: got n=%0d want 1 transfer of 11", xfers.size() - xb);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        logic [7:0] b;
        b = 8'hF0;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = b[4];
        tick(8);
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        #3 rst = 1'b1;
        #1;
        n_run++;
        if ({d_rx, vld_rx, ferr, ovr, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset: got d=%h v=%b f=%b o=%b b=%b want all 0",
                     d_rx, vld_rx, ferr, ovr, busy);
        end
        rxd = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        send_frame(8'h0F, 1'b1);
        wait_vld(20, ok);
        n_run++;
        if (!ok || d_rx !== 8'h0F) begin
            n_fail++;
            $display("FAIL mid_recover: got v=%b d=%h want v=1 d=0f", vld_rx, d_rx);
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        ferr_cnt = 0;
        ovr_cnt = 0;
        rst = 1'b1;
        rxd = 1'b1;
        rdy_rx = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
